// File: rtl/reservation_station_param.sv
// reservation_station_param: age-ordered reservation station with CDB wakeup/bypass, registered issue port and flush
module reservation_station_param #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int OPC_W  = 4,
  parameter int IMM_W  = 8,
  parameter int NCDB   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [OPC_W-1:0]           in_opcode,
  input  logic [IMM_W-1:0]           in_imm,
  input  logic [TAG_W-1:0]           in_src1_tag,
  input  logic [TAG_W-1:0]           in_src2_tag,
  input  logic [DATA_W-1:0]          in_src1_val,
  input  logic [DATA_W-1:0]          in_src2_val,
  input  logic                       in_src1_rdy,
  input  logic                       in_src2_rdy,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*TAG_W-1:0]      cdb_tag,
  input  logic [NCDB*DATA_W-1:0]     cdb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [OPC_W-1:0]           out_opcode,
  output logic [IMM_W-1:0]           out_imm,
  output logic [DATA_W-1:0]          out_val1,
  output logic [DATA_W-1:0]          out_val2,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0]  v_q, v_d, s1r_q, s1r_d, s2r_q, s2r_d, rdy;
  logic [TAG_W-1:0]  tag_q [DEPTH], tag_d [DEPTH], s1t_q [DEPTH], s1t_d [DEPTH], s2t_q [DEPTH], s2t_d [DEPTH];
  logic [OPC_W-1:0]  opc_q [DEPTH], opc_d [DEPTH];
  logic [IMM_W-1:0]  imm_q [DEPTH], imm_d [DEPTH];
  logic [DATA_W-1:0] s1v_q [DEPTH], s1v_d [DEPTH], s2v_q [DEPTH], s2v_d [DEPTH];
  // older_q[i][j] set means entry j was allocated before entry i
  logic [DEPTH-1:0]  older_q [DEPTH], older_d [DEPTH];
  logic              ov_q, ov_d;
  logic [TAG_W-1:0]  otag_q, otag_d;
  logic [OPC_W-1:0]  oopc_q, oopc_d;
  logic [IMM_W-1:0]  oimm_q, oimm_d;
  logic [DATA_W-1:0] ov1_q, ov1_d, ov2_q, ov2_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     sel, fre;
  logic              wr, ld;
  assign in_ready   = count_q < CW'(DEPTH);
  assign out_valid  = ov_q;
  assign out_tag    = otag_q;
  assign out_opcode = oopc_q;
  assign out_imm    = oimm_q;
  assign out_val1   = ov1_q;
  assign out_val2   = ov2_q;
  assign count      = count_q;
  always_comb begin
    rdy = v_q & s1r_q & s2r_q;
    sel = '0;
    fre = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i] && !(|(rdy & older_q[i]))) sel = IW'(i);
      if (!v_q[i]) fre = IW'(i);
    end
    wr = in_valid & in_ready;
    ld = (!ov_q | out_ready) & (|rdy);
    v_d = v_q; s1r_d = s1r_q; s2r_d = s2r_q;
    tag_d = tag_q; opc_d = opc_q; imm_d = imm_q;
    s1t_d = s1t_q; s2t_d = s2t_q; s1v_d = s1v_q; s2v_d = s2v_q;
    older_d = older_q;
    ov_d = ov_q; otag_d = otag_q; oopc_d = oopc_q; oimm_d = oimm_q; ov1_d = ov1_q; ov2_d = ov2_q;
    // descending port scan lets the lowest matching port win
    for (int i = 0; i < DEPTH; i++)
      for (int k = NCDB-1; k >= 0; k--) begin
        if (v_q[i] && !s1r_q[i] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s1t_q[i]) begin
          s1r_d[i] = 1'b1;
          s1v_d[i] = cdb_data[k*DATA_W +: DATA_W];
        end
        if (v_q[i] && !s2r_q[i] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s2t_q[i]) begin
          s2r_d[i] = 1'b1;
          s2v_d[i] = cdb_data[k*DATA_W +: DATA_W];
        end
      end
    if (ld) begin
      v_d[sel] = 1'b0;
      ov_d = 1'b1;
      otag_d = tag_q[sel];
      oopc_d = opc_q[sel];
      oimm_d = imm_q[sel];
      ov1_d = s1v_q[sel];
      ov2_d = s2v_q[sel];
    end else if (out_ready) ov_d = 1'b0;
    if (wr) begin
      v_d[fre] = 1'b1;
      tag_d[fre] = in_tag;
      opc_d[fre] = in_opcode;
      imm_d[fre] = in_imm;
      s1t_d[fre] = in_src1_tag;
      s2t_d[fre] = in_src2_tag;
      s1r_d[fre] = in_src1_rdy;
      s2r_d[fre] = in_src2_rdy;
      s1v_d[fre] = in_src1_val;
      s2v_d[fre] = in_src2_val;
      for (int k = NCDB-1; k >= 0; k--) begin
        if (!in_src1_rdy && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == in_src1_tag) begin
          s1r_d[fre] = 1'b1;
          s1v_d[fre] = cdb_data[k*DATA_W +: DATA_W];
        end
        if (!in_src2_rdy && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == in_src2_tag) begin
          s2r_d[fre] = 1'b1;
          s2v_d[fre] = cdb_data[k*DATA_W +: DATA_W];
        end
      end
      older_d[fre] = v_q;
      for (int i = 0; i < DEPTH; i++) older_d[i][fre] = 1'b0;
    end
    if (flush) begin
      v_d = '0;
      ov_d = 1'b0;
    end
    count_d = flush ? '0 : count_q + CW'(wr) - CW'(ld);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0; s1r_q <= '0; s2r_q <= '0;
      tag_q <= '{default: '0}; opc_q <= '{default: '0}; imm_q <= '{default: '0};
      s1t_q <= '{default: '0}; s2t_q <= '{default: '0};
      s1v_q <= '{default: '0}; s2v_q <= '{default: '0};
      older_q <= '{default: '0};
      ov_q <= 1'b0; otag_q <= '0; oopc_q <= '0; oimm_q <= '0; ov1_q <= '0; ov2_q <= '0;
      count_q <= '0;
    end else begin
      v_q <= v_d; s1r_q <= s1r_d; s2r_q <= s2r_d;
      tag_q <= tag_d; opc_q <= opc_d; imm_q <= imm_d;
      s1t_q <= s1t_d; s2t_q <= s2t_d;
      s1v_q <= s1v_d; s2v_q <= s2v_d;
      older_q <= older_d;
      ov_q <= ov_d; otag_q <= otag_d; oopc_q <= oopc_d; oimm_q <= oimm_d; ov1_q <= ov1_d; ov2_q <= ov2_d;
      count_q <= count_d;
    end
endmodule

// File: tb/tb_reservation_station_param.sv
// tb_reservation_station_param: scoreboard bench for the reservation station issue stream and control corners
module tb_reservation_station_param;
  localparam int D = 4;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0]  in_tag = '0, in_opcode = '0, in_src1_tag = '0, in_src2_tag = '0, out_tag, out_opcode;
  logic [7:0]  in_imm = '0, out_imm;
  logic [15:0] in_src1_val = '0, in_src2_val = '0, out_val1, out_val2;
  logic        in_src1_rdy = 1'b0, in_src2_rdy = 1'b0;
  logic [3:0]  cdb_valid = '0;
  logic [15:0] cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic [2:0]  count;
  typedef struct packed {logic [3:0] tag; logic [3:0] opc; logic [7:0] imm; logic [15:0] v1; logic [15:0] v2;} exp_t;
  exp_t sb[$];
  exp_t em;
  int vectors = 0, miscompares = 0;
  reservation_station_param #(.DEPTH(D), .DATA_W(16), .TAG_W(4), .OPC_W(4), .IMM_W(8), .NCDB(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_opcode(in_opcode), .in_imm(in_imm),
    .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag), .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
    .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_opcode(out_opcode), .out_imm(out_imm),
    .out_val1(out_val1), .out_val2(out_val2), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // a transfer happens at the next rising edge whenever valid & ready are seen here
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_issue", {out_tag}, 64'hF0);
      else begin
        em = sb.pop_front();
        chk("out_tag", out_tag, em.tag);
        chk("out_opcode", out_opcode, em.opc);
        chk("out_imm", out_imm, em.imm);
        chk("out_val1", out_val1, em.v1);
        chk("out_val2", out_val2, em.v2);
      end
    end
  task automatic wr(input logic [3:0] t, input logic ar, input logic [3:0] at, input logic [15:0] a,
                    input logic br, input logic [3:0] bt, input logic [15:0] b, input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    in_valid = 1'b1; in_tag = t; in_opcode = t ^ 4'h1; in_imm = {t, 4'h5};
    in_src1_rdy = ar; in_src1_tag = at; in_src1_val = a;
    in_src2_rdy = br; in_src2_tag = bt; in_src2_val = b;
    e.tag = t; e.opc = t ^ 4'h1; e.imm = {t, 4'h5}; e.v1 = ea; e.v2 = eb;
    if (in_ready) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", {out_tag, out_opcode, out_imm, out_val1, out_val2}, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    wr(4'd3, 1, 4'd0, 16'd5, 1, 4'd0, 16'd7, 16'd5, 16'd7);
    chk("lat_one_edge", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_two_edges", out_valid, 1);
    chk("lat_tag", out_tag, 3);
    drain();
    for (int i = 1; i <= 3; i++) wr(4'(i), 0, 4'd9, 16'd0, 1, 4'd0, 16'(i), 16'h00AA, 16'(i));
    chk("wait_no_issue", out_valid, 0);
    cdb_valid = 4'b0100; cdb_tag[8 +: 4] = 4'd9; cdb_data[32 +: 16] = 16'h00AA;
    @(posedge clk); #1 cdb_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("throughput", out_valid, 1);
    end
    drain();
    cdb_valid = 4'b0001; cdb_tag[0 +: 4] = 4'd6; cdb_data[0 +: 16] = 16'h1234;
    wr(4'd4, 1, 4'd0, 16'h0044, 0, 4'd6, 16'd0, 16'h0044, 16'h1234);
    cdb_valid = '0;
    drain();
    wr(4'd7, 0, 4'd5, 16'd0, 1, 4'd0, 16'd3, 16'h0011, 16'd3);
    cdb_valid = 4'b1010;
    cdb_tag[4 +: 4] = 4'd5; cdb_data[16 +: 16] = 16'h0011;
    cdb_tag[12 +: 4] = 4'd5; cdb_data[48 +: 16] = 16'h0033;
    @(posedge clk); #1 cdb_valid = '0;
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) wr(4'(8 + i), 1, 4'd0, 16'(3 * i + 1), 1, 4'd0, 16'(100 + i), 16'(3 * i + 1), 16'(100 + i));
    chk("full_count", count, D);
    chk("full_in_ready", in_ready, 0);
    wr(4'd15, 1, 4'd0, 16'hDEAD, 1, 4'd0, 16'hBEEF, 16'hDEAD, 16'hBEEF);
    chk("full_ignored", count, D);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, out_tag, out_val1, out_val2}, {1'b1, 4'd8, 16'd1, 16'd100});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("empty_out_valid", out_valid, 0);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(4'(i), 1, 4'd0, 16'(i), 1, 4'd0, 16'(i), 16'(i), 16'(i));
    chk("pre_flush_count", count, 3);
    chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1;
    wr(4'd5, 1, 4'd0, 16'd5, 1, 4'd0, 16'd5, 16'd5, 16'd5);
    flush = 1'b0;
    sb.delete();
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_write_dropped", {out_valid, count}, 0);
    out_ready = 1'b0;
    wr(4'd6, 1, 4'd0, 16'd6, 1, 4'd0, 16'd6, 16'd6, 16'd6);
    wr(4'd7, 1, 4'd0, 16'd7, 1, 4'd0, 16'd7, 16'd7, 16'd7);
    chk("pre_reset_count", count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_out", {out_valid, out_tag, out_val1}, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
